// File: rtl/vc_test_mem_responder_pkg.sv
// Shared PARCv2 memory message layout and byte-lane helpers used by the
// test memory and the core's pack/unpack helpers.
package vc_test_mem_responder_pkg;

    localparam int unsigned REQ_SZ  = 67;
    localparam int unsigned RESP_SZ = 35;

    typedef enum logic {
        TYPE_READ  = 1'b0,
        TYPE_WRITE = 1'b1
    } mem_type_e;

    typedef struct packed {
        mem_type_e   mtype;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        mem_type_e   mtype;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_t;

    // len==0 encodes a full 4-byte access
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

    function automatic logic [31:0] byte_mask(input logic [1:0] len);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < 32'(len_to_bytes(len)))
                m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/vc_test_mem_responder_lfsr8.sv
// Free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1) used to throttle request
// acceptance; bit 0 is the pseudo-random ready.
module vc_test_mem_lfsr8 (
    input  logic clk,
    input  logic rst,
    output logic lsb
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 8'hA5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign lsb = lfsr[0];

endmodule

// File: rtl/vc_test_mem_responder.sv
// Test-harness memory responder: word array with byte-lane reads/writes and a
// fixed-latency response pipeline, optionally with random request back-pressure.
module vc_test_mem_responder
    import vc_test_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned RAND_STALL = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQ_SZ-1:0]    memreq_msg,
    input  logic                 memreq_val,
    output logic                 memreq_rdy,
    output logic [RESP_SZ-1:0]   memresp_msg,
    output logic                 memresp_val,
    input  logic                 init_en,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [31:0]          init_data
);

    mem_req_t              req;
    logic                  accept;
    logic                  lfsr_lsb;
    logic [ADDR_BITS-1:0]  idx;
    logic [31:0]           mem [2**ADDR_BITS];
    logic [31:0]           rd_word;
    logic [31:0]           wr_word;
    logic [31:0]           rd_data;
    int unsigned           off_i;
    int unsigned           n_i;
    mem_resp_t             stage0_msg;
    logic                  pipe_val [LATENCY];
    mem_resp_t             pipe_msg [LATENCY];
    logic                  unused_addr_hi;

    assign req            = mem_req_t'(memreq_msg);
    assign idx            = req.addr[ADDR_BITS+1:2];
    assign unused_addr_hi = ^req.addr[31:ADDR_BITS+2];

    vc_test_mem_lfsr8 u_lfsr (
        .clk (clk),
        .rst (reset),
        .lsb (lfsr_lsb)
    );

    // Preload owns the array for the cycle, so requests are simply held off
    assign memreq_rdy = !reset && !init_en && ((RAND_STALL == 0) || lfsr_lsb);
    assign accept     = memreq_val && memreq_rdy;
    assign rd_word    = mem[idx];

    always_comb begin
        off_i   = 32'(req.addr[1:0]);
        n_i     = 32'(len_to_bytes(req.len));
        wr_word = rd_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (b >= off_i && b < off_i + n_i)
                wr_word[8*b +: 8] = req.data[8*(b - off_i) +: 8];
        end
        rd_data = (rd_word >> (8 * off_i)) & byte_mask(req.len);

        stage0_msg.mtype = req.mtype;
        stage0_msg.len   = req.len;
        stage0_msg.data  = (req.mtype == TYPE_WRITE) ? '0 : rd_data;
    end

    // Array contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (init_en)
            mem[init_addr] <= init_data;
        else if (accept && req.mtype == TYPE_WRITE)
            mem[idx] <= wr_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_val[i] <= 1'b0;
                pipe_msg[i] <= '0;
            end
        end else begin
            pipe_val[0] <= accept;
            pipe_msg[0] <= accept ? stage0_msg : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_val[i] <= pipe_val[i-1];
                pipe_msg[i] <= pipe_msg[i-1];
            end
        end
    end

    assign memresp_val = pipe_val[LATENCY-1];
    assign memresp_msg = pipe_msg[LATENCY-1];

    a_val_known: assert property (@(posedge clk) disable iff (reset)
        memreq_rdy |-> !$isunknown(memreq_val));

endmodule

// File: tb/tb_vc_test_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=3 plain, LATENCY=4 random-stall)
// checked against a byte-level memory model.
module tb_vc_test_mem_responder;

    localparam int LAT [2] = '{3, 4};

    logic        clk = 1'b0;
    logic        rst        [2];
    logic [66:0] req_msg    [2];
    logic        req_val    [2];
    logic        req_rdy    [2];
    logic [34:0] resp_msg   [2];
    logic        resp_val   [2];
    logic        init_en    [2];
    logic [9:0]  init_addr  [2];
    logic [31:0] init_data  [2];

    typedef struct {
        logic [34:0] msg;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] rmem [2][1024];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          req_cnt_b = 0;
    int          resp_cnt_b = 0;
    logic        stall_phase = 1'b0;
    int          stall_cyc = 0;
    int          stall_low = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vc_test_mem_responder #(.ADDR_BITS(10), .LATENCY(3), .RAND_STALL(0)) u_a (
        .clk(clk), .reset(rst[0]),
        .memreq_msg(req_msg[0]), .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]),
        .memresp_msg(resp_msg[0]), .memresp_val(resp_val[0]),
        .init_en(init_en[0]), .init_addr(init_addr[0]), .init_data(init_data[0])
    );

    vc_test_mem_responder #(.ADDR_BITS(10), .LATENCY(4), .RAND_STALL(1)) u_b (
        .clk(clk), .reset(rst[1]),
        .memreq_msg(req_msg[1]), .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]),
        .memresp_msg(resp_msg[1]), .memresp_val(resp_val[1]),
        .init_en(init_en[1]), .init_addr(init_addr[1]), .init_data(init_data[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference access: walk the requested bytes, dropping any past byte 3
    function automatic logic [31:0] model_access(input int u, input logic t,
            input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
        int unsigned idx;
        int unsigned off;
        int unsigned n;
        int unsigned pos;
        logic [31:0] r;
        idx = (addr / 4) % 1024;
        off = addr % 4;
        n   = (len == 2'd0) ? 4 : int'(len);
        r   = 32'd0;
        for (int unsigned k = 0; k < n; k++) begin
            pos = off + k;
            if (pos < 4) begin
                if (t) rmem[u][idx][8*pos +: 8] = data[8*k +: 8];
                else   r[8*k +: 8] = rmem[u][idx][8*pos +: 8];
            end
        end
        return t ? 32'd0 : r;
    endfunction

    task automatic send(input int u, input logic t, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        req_msg[u] = {t, addr, len, data};
        req_val[u] = 1'b1;
        while (req_rdy[u] !== 1'b1) begin
            waited++;
            if (waited > 200) begin
                check("rdy_timeout", 64'(req_rdy[u]), 64'd1);
                req_val[u] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.msg = {t, len, model_access(u, t, addr, len, data)};
        e.cyc = cyc + LAT[u];
        if (u == 0) qa.push_back(e);
        else begin
            qb.push_back(e);
            req_cnt_b++;
        end
        @(posedge clk);
        #1 req_val[u] = 1'b0;
    endtask

    task automatic preload(input int u, input int unsigned idx, input logic [31:0] d);
        @(negedge clk);
        init_en[u]   = 1'b1;
        init_addr[u] = 10'(idx);
        init_data[u] = d;
        @(posedge clk);
        #1 init_en[u] = 1'b0;
        rmem[u][idx] = d;
    endtask

    task automatic mon(input int u);
        exp_t e;
        int   qs;
        qs = (u == 0) ? qa.size() : qb.size();
        if (resp_val[u] === 1'b1) begin
            if (u == 1) resp_cnt_b++;
            if (qs == 0) begin
                check("spurious_resp", 64'(resp_val[u]), 64'd0);
            end else begin
                e = (u == 0) ? qa.pop_front() : qb.pop_front();
                check("resp_msg", 64'(resp_msg[u]), 64'(e.msg));
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (qs != 0) begin
            e = (u == 0) ? qa[0] : qb[0];
            if (cyc > e.cyc) begin
                if (u == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
                check("missing_resp", 64'(resp_val[u]), 64'd1);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        if (stall_phase) begin
            stall_cyc++;
            if (req_rdy[1] !== 1'b1) stall_low++;
        end
    end

    task automatic drain(input int u);
        for (int i = 0; i < 60; i++) begin
            if (((u == 0) ? qa.size() : qb.size()) == 0) break;
            @(negedge clk);
        end
        check("drain", 64'((u == 0) ? qa.size() : qb.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req_val[u] = 1'b0; req_msg[u] = '0;
            init_en[u] = 1'b0; init_addr[u] = '0; init_data[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_rdy", 64'(req_rdy[u]), 64'd0);
            check("reset_val", 64'(resp_val[u]), 64'd0);
            check("reset_msg", 64'(resp_msg[u]), 64'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1 check("rdy_after_reset", 64'(req_rdy[0]), 64'd1);

        // Word write then read (also back-to-back ordering)
        send(0, 1'b1, 32'h100, 2'd0, 32'hDEADBEEF);
        send(0, 1'b0, 32'h100, 2'd0, 32'h0);
        drain(0);
        // Subword read/write and crossing write
        preload(0, 32'h40, 32'h11223344);
        preload(0, 32'h41, 32'h55667788);
        send(0, 1'b0, 32'h102, 2'd1, 32'h0);
        send(0, 1'b1, 32'h101, 2'd2, 32'h0000AABB);
        send(0, 1'b0, 32'h100, 2'd0, 32'h0);
        send(0, 1'b1, 32'h103, 2'd2, 32'h0000CCDD);
        send(0, 1'b0, 32'h100, 2'd0, 32'h0);
        send(0, 1'b0, 32'h104, 2'd0, 32'h0);
        drain(0);
        // Four back-to-back requests, aliased addresses included
        send(0, 1'b0, 32'h101, 2'd3, 32'h0);
        send(0, 1'b0, 32'hFFFF_F105, 2'd2, 32'h0);
        send(0, 1'b1, 32'h0000_1106, 2'd1, 32'h0000_0099);
        send(0, 1'b0, 32'h104, 2'd0, 32'h0);
        drain(0);

        // Random traffic under back-pressure
        for (int i = 0; i < 16; i++) preload(1, i, $urandom);
        preload(1, 20, 32'hCAFEF00D);
        stall_phase = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (($urandom % 16) << 2) | ($urandom % 4);
            send(1, 1'($urandom % 2), a, 2'($urandom % 4), $urandom);
        end
        stall_phase = 1'b0;
        drain(1);
        check("req_resp_count", 64'(resp_cnt_b), 64'(req_cnt_b));
        check("stall_ratio_ge_20pct", 64'(stall_low * 5 >= stall_cyc), 64'd1);

        // Reset while a response is in flight
        send(1, 1'b0, 32'h50, 2'd0, 32'h0);
        @(posedge clk);
        #1 rst[1] = 1'b1;
        qb.delete();
        repeat (3) begin
            @(negedge clk);
            check("val_in_reset", 64'(resp_val[1]), 64'd0);
        end
        rst[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("val_after_reset", 64'(resp_val[1]), 64'd0);
        end
        send(1, 1'b0, 32'h50, 2'd0, 32'h0);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
